// File: rtl/wdog_pkg.sv
// rtl/wdog_pkg.sv - watchdog register map, key, op/state enums and write-step helpers
package wdog_pkg;

    localparam logic [11:0] REG_LOAD    = 12'h000;
    localparam logic [11:0] REG_CONTROL = 12'h008;
    localparam logic [11:0] REG_INTCLR  = 12'h00C;
    localparam logic [11:0] REG_LOCK    = 12'hC00;
    localparam logic [31:0] UNLOCK_KEY  = 32'h1ACCE551;

    typedef enum logic {OP_CFG, OP_KICK} op_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    // Every sequence ends with the relock write; its step index depends on the op.
    function automatic logic [1:0] last_step(input op_t op);
        return (op == OP_CFG) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [11:0] step_addr(input op_t op, input logic [1:0] step);
        if (step == 2'd0 || step == last_step(op)) return REG_LOCK;
        if (op == OP_KICK) return REG_INTCLR;
        return (step == 2'd1) ? REG_LOAD : REG_CONTROL;
    endfunction

    function automatic logic [31:0] step_data(input op_t op, input logic [1:0] step,
                                              input logic [31:0] load, input logic [1:0] ctrl);
        if (step == 2'd0) return UNLOCK_KEY;
        if (step == last_step(op)) return 32'h0;
        if (op == OP_KICK) return 32'h1;
        return (step == 2'd1) ? load : {30'b0, ctrl};
    endfunction

endpackage

// File: rtl/wdog_kick_timer.sv
// rtl/wdog_kick_timer.sv - periodic auto-kick counter raising a sticky pending flag
module wdog_kick_timer #(
    parameter int AUTO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [AUTO_W-1:0] period,
    input  logic              restart,
    input  logic              clr,
    output logic              pend
);

    localparam logic [AUTO_W-1:0] ONE = {{(AUTO_W-1){1'b0}}, 1'b1};

    logic [AUTO_W-1:0] cnt;
    logic              active;
    logic              hit;

    assign active = en && (period != '0);
    // >= rather than == so a period shortened below the running count wraps at once
    assign hit    = active && (cnt >= period - ONE);

    // Counter held at 0 while disabled (covers auto_en falling); set beats clear on pend
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (!active || restart || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
            pend <= hit || (pend && !clr);
        end
    end

endmodule

// File: rtl/wdog_service_ctrl.sv
// rtl/wdog_service_ctrl.sv - APB master running unlock/write/relock sequences on the watchdog
module wdog_service_ctrl
    import wdog_pkg::*;
#(
    parameter int AUTO_W = 16
) (
    input  logic              apb_clk,
    input  logic              apb_rst,
    input  logic              cfg_req,
    input  logic [31:0]       cfg_load,
    input  logic [1:0]        cfg_ctrl,
    output logic              cfg_ack,
    input  logic              kick_req,
    output logic              kick_ack,
    input  logic              auto_en,
    input  logic [AUTO_W-1:0] auto_period,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [11:0]       paddr,
    output logic [31:0]       pwdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              err
);

    state_t      state;
    op_t         op;
    logic [1:0]  step;
    logic [1:0]  next_step;
    logic        manual;
    logic [31:0] act_load;
    logic [1:0]  act_ctrl;
    logic [31:0] cap_load;
    logic [1:0]  cap_ctrl;
    logic        cfg_pend;
    logic        kick_pend;
    logic        auto_pend;
    logic        cfg_go;
    logic        kick_go;
    logic        cur_relock;
    logic        seq_end;
    logic        kick_end;

    assign cfg_go     = cfg_req || cfg_pend;
    assign kick_go    = kick_req || kick_pend || auto_pend;
    assign cur_relock = (step == last_step(op));
    assign seq_end    = (state == ACCESS) && pready && cur_relock;
    assign kick_end   = seq_end && (op == OP_KICK);
    // A slave error skips straight to the relock so the watchdog is never left unlocked
    assign next_step  = pslverr ? last_step(op) : step + 2'd1;

    // Request capture: cfg is consumed at grant, kick stays pending until a kick completes
    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            cfg_pend  <= 1'b0;
            kick_pend <= 1'b0;
            cap_load  <= '0;
            cap_ctrl  <= '0;
        end else begin
            cfg_pend  <= (state != IDLE) && cfg_go;
            kick_pend <= kick_req || (kick_pend && !kick_end);
            if (cfg_req) begin
                cap_load <= cfg_load;
                cap_ctrl <= cfg_ctrl;
            end
        end
    end

    // Sequencer: arbitration, APB phases and registered bus/ack/status outputs
    always_ff @(posedge apb_clk) begin
        if (apb_rst) begin
            state    <= IDLE;
            op       <= OP_CFG;
            step     <= '0;
            manual   <= 1'b0;
            act_load <= '0;
            act_ctrl <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cfg_ack  <= 1'b0;
            kick_ack <= 1'b0;
        end else begin
            cfg_ack  <= 1'b0;
            kick_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_go || kick_go) begin
                        state   <= SETUP;
                        step    <= '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= 1'b1;
                        busy    <= 1'b1;
                        paddr   <= REG_LOCK;
                        pwdata  <= UNLOCK_KEY;
                        if (cfg_go) begin
                            op       <= OP_CFG;
                            err      <= 1'b0;
                            act_load <= cfg_req ? cfg_load : cap_load;
                            act_ctrl <= cfg_req ? cfg_ctrl : cap_ctrl;
                        end else begin
                            op     <= OP_KICK;
                            manual <= kick_req || kick_pend;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        if (pslverr) begin
                            err <= 1'b1;
                        end
                        if (cur_relock) begin
                            state    <= DONE;
                            psel     <= 1'b0;
                            penable  <= 1'b0;
                            pwrite   <= 1'b0;
                            cfg_ack  <= (op == OP_CFG);
                            kick_ack <= (op == OP_KICK) && manual;
                        end else begin
                            state   <= SETUP;
                            penable <= 1'b0;
                            step    <= next_step;
                            paddr   <= step_addr(op, next_step);
                            pwdata  <= step_data(op, next_step, act_load, act_ctrl);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    wdog_kick_timer #(
        .AUTO_W(AUTO_W)
    ) u_kick_timer (
        .clk     (apb_clk),
        .rst     (apb_rst),
        .en      (auto_en),
        .period  (auto_period),
        .restart (seq_end),
        .clr     (kick_end),
        .pend    (auto_pend)
    );

endmodule

// File: tb/tb_wdog_service_ctrl.sv
// tb/tb_wdog_service_ctrl.sv - self-checking bench for wdog_service_ctrl
module tb_wdog_service_ctrl;
    import wdog_pkg::*;

    localparam int AUTO_W = 16;

    logic              apb_clk = 1'b0;
    logic              apb_rst = 1'b1;
    logic              cfg_req = 1'b0;
    logic [31:0]       cfg_load = '0;
    logic [1:0]        cfg_ctrl = '0;
    logic              cfg_ack;
    logic              kick_req = 1'b0;
    logic              kick_ack;
    logic              auto_en = 1'b0;
    logic [AUTO_W-1:0] auto_period = '0;
    logic              psel, penable, pwrite;
    logic [11:0]       paddr;
    logic [31:0]       pwdata;
    logic              pready = 1'b1;
    logic              pslverr = 1'b0;
    logic              busy, err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          setup_q[$];
    int          key_q[$];
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          cack_q[$];
    int          kack_q[$];
    int          busy_q[$];
    int          stab_bad = 0;
    int          pwr_bad = 0;
    logic [11:0] sa = '0;
    logic [31:0] sd = '0;

    int   wait_n = 0;
    int   wcnt = 0;
    logic inject = 1'b0;

    always #5 apb_clk = ~apb_clk;
    always @(posedge apb_clk) cyc <= cyc + 1;

    wdog_service_ctrl #(.AUTO_W(AUTO_W)) dut (
        .apb_clk(apb_clk), .apb_rst(apb_rst),
        .cfg_req(cfg_req), .cfg_load(cfg_load), .cfg_ctrl(cfg_ctrl), .cfg_ack(cfg_ack),
        .kick_req(kick_req), .kick_ack(kick_ack),
        .auto_en(auto_en), .auto_period(auto_period),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .busy(busy), .err(err)
    );

    // Slave: wait_n low-pready cycles per ACCESS, optional error on the LOAD write
    initial begin
        forever begin
            @(posedge apb_clk);
            #1;
            if (psel === 1'b1 && penable === 1'b1) begin
                if (wcnt < wait_n) begin
                    pready = 1'b0; pslverr = 1'b0; wcnt++;
                end else begin
                    pready = 1'b1; pslverr = inject && (paddr == REG_LOAD); wcnt = 0;
                end
            end else begin
                pready = (wait_n == 0); pslverr = 1'b0; wcnt = 0;
            end
        end
    end

    // Bus/ack logger
    always @(negedge apb_clk) begin
        if (psel === 1'b1 && penable === 1'b0) begin
            setup_q.push_back(cyc);
            if (pwdata == UNLOCK_KEY) key_q.push_back(cyc);
            sa <= paddr;
            sd <= pwdata;
        end
        if (psel === 1'b1 && penable === 1'b1) begin
            if (paddr !== sa || pwdata !== sd) stab_bad <= stab_bad + 1;
            if (pready) begin
                wa_q.push_back(paddr);
                wd_q.push_back(pwdata);
            end
        end
        if (psel === 1'b1 && pwrite !== 1'b1) pwr_bad <= pwr_bad + 1;
        if (cfg_ack === 1'b1) cack_q.push_back(cyc);
        if (kick_ack === 1'b1) kack_q.push_back(cyc);
        if (busy === 1'b1) busy_q.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge apb_clk);
        #1;
    endtask

    task automatic pulse(input logic c, input logic k, output int c0);
        @(posedge apb_clk);
        #1;
        cfg_req = c; kick_req = k; c0 = cyc;
        @(posedge apb_clk);
        #1;
        cfg_req = 1'b0; kick_req = 1'b0;
    endtask

    task automatic test_reset;
        apb_rst = 1'b1;
        tick(3);
        total++;
        if ({psel, penable, pwrite, paddr, pwdata, cfg_ack, kick_ack, busy, err} !== 51'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {psel, penable, pwrite, paddr, pwdata, cfg_ack, kick_ack, busy, err});
        end
        apb_rst = 1'b0;
        tick(3);
        total++;
        if ({psel, busy, cfg_ack, kick_ack} !== 4'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=0000", {psel, busy, cfg_ack, kick_ack});
        end
    endtask

    task automatic test_cfg;
        int c0, w, per, ack_rel, bw, bs, bc, bk, bb, sb, got;
        logic [31:0] load;
        logic [1:0]  ctrl;
        logic [11:0] ea[4];
        logic [31:0] ed[4];
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                w = 0; load = 32'h0000_0100; ctrl = 2'b11;
            end else begin
                w = $urandom_range(0, 2); load = $urandom; ctrl = 2'($urandom_range(0, 3));
            end
            wait_n = w;
            bw = wa_q.size(); bs = setup_q.size(); bc = cack_q.size();
            bk = kack_q.size(); bb = busy_q.size(); sb = stab_bad;
            cfg_load = load; cfg_ctrl = ctrl;
            pulse(1'b1, 1'b0, c0);
            cfg_load = $urandom; cfg_ctrl = 2'($urandom_range(0, 3));
            per = 2 + w;
            ack_rel = 1 + 4 * per;
            tick(ack_rel + 2);
            ea = '{REG_LOCK, REG_LOAD, REG_CONTROL, REG_LOCK};
            ed = '{UNLOCK_KEY, load, {30'b0, ctrl}, 32'h0};
            total++;
            if (wa_q.size() - bw !== 4) begin
                bad++; $display("FAIL cfg_write_count got=%0d want=4", wa_q.size() - bw);
            end
            for (int k = 0; k < 4; k++) begin
                if (bw + k < wa_q.size()) begin
                    total++;
                    if ({wa_q[bw+k], wd_q[bw+k]} !== {ea[k], ed[k]}) begin
                        bad++;
                        $display("FAIL cfg_write[%0d] got=%h/%h want=%h/%h", k, wa_q[bw+k], wd_q[bw+k], ea[k], ed[k]);
                    end
                end
                if (bs + k < setup_q.size()) begin
                    total++;
                    if (setup_q[bs+k] - c0 !== 1 + k * per) begin
                        bad++;
                        $display("FAIL cfg_setup_cycle[%0d] got=%0d want=%0d", k, setup_q[bs+k] - c0, 1 + k * per);
                    end
                end
            end
            got = (cack_q.size() > bc) ? cack_q[bc] - c0 : -1;
            total++;
            if (cack_q.size() - bc !== 1 || got !== ack_rel) begin
                bad++; $display("FAIL cfg_ack_cycle got=%0d want=%0d", got, ack_rel);
            end
            total++;
            if (kack_q.size() - bk !== 0) begin
                bad++; $display("FAIL cfg_no_kick_ack got=%0d want=0", kack_q.size() - bk);
            end
            got = (busy_q.size() > bb) ? busy_q[bb] - c0 : -1;
            total++;
            if (busy_q.size() - bb !== ack_rel || got !== 1) begin
                bad++;
                $display("FAIL cfg_busy got=%0d@%0d want=%0d@1", busy_q.size() - bb, got, ack_rel);
            end
            total++;
            if (stab_bad - sb !== 0) begin
                bad++; $display("FAIL cfg_bus_stable got=%0d want=0", stab_bad - sb);
            end
        end
        wait_n = 0;
    endtask

    task automatic test_kick_wait;
        int c0, bw, bs, bc, bk, got;
        logic [11:0] ea[3];
        logic [31:0] ed[3];
        wait_n = 2;
        bw = wa_q.size(); bs = setup_q.size(); bc = cack_q.size(); bk = kack_q.size();
        pulse(1'b0, 1'b1, c0);
        tick(16);
        ea = '{REG_LOCK, REG_INTCLR, REG_LOCK};
        ed = '{UNLOCK_KEY, 32'h1, 32'h0};
        total++;
        if (wa_q.size() - bw !== 3) begin
            bad++; $display("FAIL kick_write_count got=%0d want=3", wa_q.size() - bw);
        end
        for (int k = 0; k < 3; k++) begin
            if (bw + k < wa_q.size()) begin
                total++;
                if ({wa_q[bw+k], wd_q[bw+k]} !== {ea[k], ed[k]}) begin
                    bad++;
                    $display("FAIL kick_write[%0d] got=%h/%h want=%h/%h", k, wa_q[bw+k], wd_q[bw+k], ea[k], ed[k]);
                end
            end
            if (bs + k < setup_q.size()) begin
                total++;
                if (setup_q[bs+k] - c0 !== 1 + 4 * k) begin
                    bad++;
                    $display("FAIL kick_setup_cycle[%0d] got=%0d want=%0d", k, setup_q[bs+k] - c0, 1 + 4 * k);
                end
            end
        end
        got = (kack_q.size() > bk) ? kack_q[bk] - c0 : -1;
        total++;
        if (kack_q.size() - bk !== 1 || got !== 13) begin
            bad++; $display("FAIL kick_ack_cycle got=%0d want=13", got);
        end
        total++;
        if (cack_q.size() - bc !== 0) begin
            bad++; $display("FAIL kick_no_cfg_ack got=%0d want=0", cack_q.size() - bc);
        end
        wait_n = 0;
    endtask

    task automatic test_back_to_back;
        int c0, d, bw, bs, bc, bk, st, cack_exp, kack_exp, gc, gk;
        logic [31:0] load;
        logic [11:0] ea[7];
        logic [31:0] ed[7];
        int          es[7];
        wait_n = 0;
        load = $urandom;
        bw = wa_q.size(); bs = setup_q.size(); bc = cack_q.size(); bk = kack_q.size();
        cfg_load = load; cfg_ctrl = 2'b01;
        pulse(1'b1, 1'b1, c0);
        pulse(1'b0, 1'b1, d);
        pulse(1'b0, 1'b1, d);
        tick(17);
        ea = '{REG_LOCK, REG_LOAD, REG_CONTROL, REG_LOCK, REG_LOCK, REG_INTCLR, REG_LOCK};
        ed = '{UNLOCK_KEY, load, 32'h1, 32'h0, UNLOCK_KEY, 32'h1, 32'h0};
        st = 1;
        for (int k = 0; k < 4; k++) es[k] = st + 2 * k;
        cack_exp = st + 8;
        st = cack_exp + 2;
        for (int k = 0; k < 3; k++) es[4+k] = st + 2 * k;
        kack_exp = st + 6;
        total++;
        if (wa_q.size() - bw !== 7) begin
            bad++; $display("FAIL b2b_write_count got=%0d want=7", wa_q.size() - bw);
        end
        for (int k = 0; k < 7; k++) begin
            if (bw + k < wa_q.size() && bs + k < setup_q.size()) begin
                total++;
                if ({wa_q[bw+k], wd_q[bw+k]} !== {ea[k], ed[k]} || setup_q[bs+k] - c0 !== es[k]) begin
                    bad++;
                    $display("FAIL b2b_write[%0d] got=%h/%h@%0d want=%h/%h@%0d", k, wa_q[bw+k], wd_q[bw+k],
                             setup_q[bs+k] - c0, ea[k], ed[k], es[k]);
                end
            end
        end
        gc = (cack_q.size() > bc) ? cack_q[bc] - c0 : -1;
        gk = (kack_q.size() > bk) ? kack_q[bk] - c0 : -1;
        total++;
        if (cack_q.size() - bc !== 1 || kack_q.size() - bk !== 1 || gc !== cack_exp || gk !== kack_exp) begin
            bad++; $display("FAIL b2b_acks got=%0d/%0d want=%0d/%0d", gc, gk, cack_exp, kack_exp);
        end
        total++;
        if (pwr_bad !== 0) begin
            bad++; $display("FAIL pwrite_high got=%0d want=0", pwr_bad);
        end
    endtask

    task automatic test_done_capture;
        int c0, d, bs, bk, gs, gk;
        wait_n = 0;
        bs = setup_q.size(); bk = kack_q.size();
        cfg_load = $urandom; cfg_ctrl = 2'b10;
        pulse(1'b1, 1'b0, c0);
        tick(7);
        pulse(1'b0, 1'b1, d);
        tick(10);
        gs = (setup_q.size() > bs + 4) ? setup_q[bs+4] - c0 : -1;
        gk = (kack_q.size() > bk) ? kack_q[bk] - c0 : -1;
        total++;
        if (d - c0 !== 9 || gs !== 11 || gk !== 17) begin
            bad++; $display("FAIL done_capture got=req%0d/setup%0d/ack%0d want=req9/setup11/ack17", d - c0, gs, gk);
        end
    endtask

    task automatic test_auto;
        int p, bk, bka, bw, after;
        for (int r = 0; r < 2; r++) begin
            p = (r == 0) ? 1 : $urandom_range(20, 60);
            bk = key_q.size(); bka = kack_q.size(); bw = wa_q.size();
            auto_period = AUTO_W'(p);
            auto_en = 1'b1;
            tick(p + 3 * (p + 7) + 10);
            total++;
            if (key_q.size() - bk < 3) begin
                bad++; $display("FAIL auto_seq_count p=%0d got=%0d want>=3", p, key_q.size() - bk);
            end
            for (int i = 0; i < 2; i++) begin
                if (bk + i + 1 < key_q.size()) begin
                    total++;
                    if (key_q[bk+i+1] - key_q[bk+i] !== p + 7) begin
                        bad++;
                        $display("FAIL auto_interval p=%0d got=%0d want=%0d", p, key_q[bk+i+1] - key_q[bk+i], p + 7);
                    end
                end
            end
            if (bw + 1 < wa_q.size()) begin
                total++;
                if (wa_q[bw+1] !== REG_INTCLR) begin
                    bad++; $display("FAIL auto_intclr got=%h want=%h", wa_q[bw+1], REG_INTCLR);
                end
            end
            total++;
            if (kack_q.size() - bka !== 0) begin
                bad++; $display("FAIL auto_no_ack got=%0d want=0", kack_q.size() - bka);
            end
            auto_en = 1'b0;
            tick(12);
            after = key_q.size();
            tick(2 * p + 20);
            total++;
            if (key_q.size() - after !== 0) begin
                bad++; $display("FAIL auto_disabled got=%0d want=0", key_q.size() - after);
            end
        end
        auto_period = '0;
    endtask

    task automatic test_slverr;
        int c0, bw, bc, got;
        logic [31:0] load;
        wait_n = 0;
        load = $urandom;
        bw = wa_q.size(); bc = cack_q.size();
        inject = 1'b1;
        cfg_load = load; cfg_ctrl = 2'b01;
        pulse(1'b1, 1'b0, c0);
        tick(10);
        inject = 1'b0;
        total++;
        if (wa_q.size() - bw !== 3) begin
            bad++; $display("FAIL slverr_write_count got=%0d want=3", wa_q.size() - bw);
        end else begin
            total++;
            if ({wa_q[bw+1], wd_q[bw+1], wa_q[bw+2], wd_q[bw+2]} !== {REG_LOAD, load, REG_LOCK, 32'h0}) begin
                bad++;
                $display("FAIL slverr_relock got=%h/%h,%h/%h want=%h/%h,%h/0", wa_q[bw+1], wd_q[bw+1],
                         wa_q[bw+2], wd_q[bw+2], REG_LOAD, load, REG_LOCK);
            end
        end
        got = (cack_q.size() > bc) ? cack_q[bc] - c0 : -1;
        total++;
        if (got !== 7) begin
            bad++; $display("FAIL slverr_ack got=%0d want=7", got);
        end
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL slverr_err_set got=%b want=1", err);
        end
        bw = wa_q.size();
        pulse(1'b1, 1'b0, c0);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL slverr_err_clear got=err%b/busy%b want=err0/busy1", err, busy);
        end
        tick(10);
        total++;
        if (wa_q.size() - bw !== 4 || err !== 1'b0) begin
            bad++; $display("FAIL slverr_recover got=%0d/err%b want=4/err0", wa_q.size() - bw, err);
        end
    endtask

    task automatic test_reset_mid;
        int c0, bs, bc, bk;
        wait_n = 0;
        pulse(1'b0, 1'b1, c0);
        @(posedge apb_clk);
        #1;
        cfg_req = 1'b1;
        @(posedge apb_clk);
        #1;
        cfg_req = 1'b0;
        @(posedge apb_clk);
        #1;
        total++;
        if ({psel, penable, paddr} !== {1'b1, 1'b1, REG_INTCLR}) begin
            bad++; $display("FAIL rst_mid_pre got=%b%b/%h want=11/%h", psel, penable, paddr, REG_INTCLR);
        end
        apb_rst = 1'b1;
        @(posedge apb_clk);
        #1;
        total++;
        if ({psel, penable, pwrite, busy, cfg_ack, kick_ack} !== 6'b0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b want=000000", {psel, penable, pwrite, busy, cfg_ack, kick_ack});
        end
        apb_rst = 1'b0;
        bs = setup_q.size(); bc = cack_q.size(); bk = kack_q.size();
        tick(25);
        total++;
        if ((setup_q.size() - bs) + (cack_q.size() - bc) + (kack_q.size() - bk) !== 0) begin
            bad++;
            $display("FAIL rst_mid_pending got=%0d/%0d/%0d want=0/0/0", setup_q.size() - bs,
                     cack_q.size() - bc, kack_q.size() - bk);
        end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_kick_wait();
        test_back_to_back();
        test_done_capture();
        test_auto();
        test_slverr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wdog_service_ctrl.md
# wdog_service_ctrl

APB-master sequencer that configures and services the watchdog peripheral on behalf of system software or autonomous logic. It turns single-cycle configure/kick requests and an optional periodic auto-kick into the watchdog's mandated register sequence (unlock, write, relock) on the watchdog APB port. It sits on the apb_clk domain between the control plane and the watchdog slave, which it owns exclusively.

## Interface
- AUTO_W, 16, width of auto-kick period counter
- apb_clk  in  1  sole clock
- apb_rst  in  1  synchronous, active-high reset
- cfg_req  in  1  one-cycle pulse: program watchdog; cfg_load/cfg_ctrl captured on this cycle
- cfg_load  in  32  value for WDOGLOAD
- cfg_ctrl  in  2  {RESEN, INTEN} for WDOGCONTROL
- cfg_ack  out  1  one-cycle pulse when configure sequence ends
- kick_req  in  1  one-cycle pulse: service (clear interrupt / reload)
- kick_ack  out  1  one-cycle pulse when kick sequence ends
- auto_en  in  1  enable periodic auto-kick
- auto_period  in  AUTO_W  auto-kick interval in apb_clk cycles; 0 = disabled
- psel, penable, pwrite  out  1  APB master controls
- paddr  out  12  APB address
- pwdata  out  32  APB write data
- pready  in  1  slave ready
- pslverr  in  1  slave error, valid with pready
- busy  out  1  sequence in progress
- err  out  1  sticky; set on pslverr, cleared by reset or next accepted cfg_req

## Operation
- Register map: LOAD 0x000, CONTROL 0x008, INTCLR 0x00C, LOCK 0xC00; unlock key 0x1ACCE551; relock writes 0x0.
- CFG sequence: LOCK<=key, LOAD<=cfg_load, CONTROL<={30'b0,cfg_ctrl}, LOCK<=0 (4 writes).
- KICK sequence: LOCK<=key, INTCLR<=1, LOCK<=0 (3 writes). Auto-kick runs the same sequence, no ack pulse.
- Requests latch into pending flags (cfg_pend, kick_pend, auto_pend); repeat pulses while pending merge into one. cfg_req while cfg_pend overwrites captured load/ctrl.
- Arbitration in IDLE: cfg > kick > auto. A completed kick (manual or auto) clears both kick_pend and auto_pend.
- Auto counter: counts when auto_en && auto_period!=0; at count == auto_period-1 sets auto_pend and wraps to 0. Counter restarts at 0 on any completed kick or cfg, and when auto_en falls. auto_period=1 → pending every cycle.
- FSM: IDLE -> SETUP (psel=1, penable=0) -> ACCESS (psel=1, penable=1, held until pready) -> SETUP of next write, or DONE after last write -> IDLE. DONE pulses the ack for the active op.
- pslverr on any write: set err; if failing write is not a LOCK write, jump to relock write (LOCK<=0), then DONE; if failing write is the relock itself, go to DONE. Ack still pulses.
- Only writes are issued; pwrite=1 whenever psel=1.

## Timing
- Reset values: psel, penable, pwrite, paddr, pwdata, cfg_ack, kick_ack, busy, err all 0; FSM IDLE; pending flags and auto counter 0.
- Zero-wait slave: req pulse at cycle 0, first SETUP at cycle 1, consecutive writes back-to-back (psel stays high, penable low for one cycle between writes); CFG ack at cycle 9, KICK ack at cycle 7. Each pready=0 cycle adds one.
- busy=1 from first SETUP through DONE inclusive.
- paddr/pwdata stable from SETUP through completing ACCESS.
- Request arriving on the same cycle as DONE is captured and starts at the cycle after IDLE.
- apb_rst mid-transfer: all outputs to reset values on next edge; transfer abandoned, watchdog left as-is (possibly unlocked).

## Structure
- Package wdog_pkg: register offsets, unlock key, op enum {OP_CFG, OP_KICK}, FSM state enum {IDLE, SETUP, ACCESS, DONE}.
- Sub-module wdog_kick_timer: auto-kick counter and auto_pend generation.

## Test plan
- cfg_req, load=0x0000_0100, ctrl=2'b11, pready=1 -> writes 0xC00=0x1ACCE551, 0x000=0x100, 0x008=0x3, 0xC00=0 on cycles 1-8; cfg_ack at 9.
- kick_req with pready low 2 cycles per ACCESS -> 3 writes (key, INTCLR=1, 0), kick_ack at cycle 13.
- cfg_req and kick_req same cycle -> CFG sequence first, KICK immediately after; both acks, cfg_ack first.
- auto_en=1, auto_period=50, no requests -> KICK sequence starts every 50+7 cycles; no kick_ack.
- pslverr on LOAD write -> next write is LOCK<=0, err=1, cfg_ack pulses; next cfg_req clears err.
- apb_rst during ACCESS of INTCLR -> psel/penable 0 next cycle, busy 0, pending cleared, no ack.
